// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for imem_loader.
//   byte_in/byte_valid/byte_ready : byte stream, accepted when valid & ready
//   mem_we/mem_addr/mem_wdata     : one-cycle word write into instruction memory
// slave  = loader side (consumes bytes, produces writes)
// master = stream source / memory side
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a length-prefixed, XOR-checksummed byte
// stream into little-endian 32-bit words and writes them to instruction memory
// while holding the core.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle pulse that begins (or restarts) a load
//   bus        : byte stream in, memory write out (imem_loader_if.slave)
//   core_hold  : keeps core/PC in reset while loading or after an error
//   done       : load completed with good checksum (level)
//   error      : load aborted on length or checksum error (level)
module imem_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    imem_loader_if.slave   bus,
    output logic           core_hold,
    output logic           done,
    output logic           error
);
    localparam int unsigned LEN_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]        state, state_n;
    logic [LEN_W-1:0]  len, len_n;
    logic [LEN_W-1:0]  word_cnt, word_cnt_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [7:0]        csum, csum_n;
    logic [23:0]       shift, shift_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [31:0]       mem_wdata_q, mem_wdata_n;
    logic              byte_ready_q, byte_ready_n;
    logic              core_hold_n, done_n, error_n;
    logic              accept_c;
    logic [LEN_W-1:0]  len_full_c;

    assign accept_c   = bus.byte_valid & byte_ready_q;
    assign len_full_c = {bus.byte_in, len[7:0]};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            len          <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            csum         <= '0;
            shift        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            byte_ready_q <= 1'b0;
            core_hold    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            len          <= len_n;
            word_cnt     <= word_cnt_n;
            byte_cnt     <= byte_cnt_n;
            csum         <= csum_n;
            shift        <= shift_n;
            mem_we_q     <= mem_we_n;
            mem_addr_q   <= mem_addr_n;
            mem_wdata_q  <= mem_wdata_n;
            byte_ready_q <= byte_ready_n;
            core_hold    <= core_hold_n;
            done         <= done_n;
            error        <= error_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        len_n       = len;
        word_cnt_n  = word_cnt;
        byte_cnt_n  = byte_cnt;
        csum_n      = csum;
        shift_n     = shift;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;

        // Advance the write pointer the cycle after a write, unless that was the last word.
        if (mem_we_q && (word_cnt != len)) begin
            mem_addr_n = mem_addr_q + ADDR_W'(1);
        end

        case (state)
            S_IDLE, S_FIN, S_ERR: begin
                if (start) begin
                    state_n    = S_LEN0;
                    word_cnt_n = '0;
                    byte_cnt_n = '0;
                    csum_n     = '0;
                    mem_addr_n = '0;
                end
            end
            S_LEN0: begin
                if (accept_c) begin
                    len_n   = {len[15:8], bus.byte_in};
                    state_n = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept_c) begin
                    len_n = len_full_c;
                    if (len_full_c > LEN_W'(DEPTH)) begin
                        state_n = S_ERR;
                    end else if (len_full_c == '0) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    csum_n     = csum ^ bus.byte_in;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_we_n    = 1'b1;
                        mem_wdata_n = {bus.byte_in, shift};
                        word_cnt_n  = word_cnt + LEN_W'(1);
                        if ((word_cnt + LEN_W'(1)) == len) begin
                            state_n = S_CHECK;
                        end
                    end else begin
                        // First byte ends up in bits 7:0 after three shifts.
                        shift_n = {bus.byte_in, shift[23:8]};
                    end
                end
            end
            S_CHECK: begin
                if (accept_c) begin
                    state_n = (bus.byte_in == csum) ? S_FIN : S_ERR;
                end
            end
            default: state_n = S_IDLE;
        endcase

        byte_ready_n = (state_n == S_LEN0) || (state_n == S_LEN1) ||
                       (state_n == S_DATA) || (state_n == S_CHECK);
        core_hold_n  = byte_ready_n || (state_n == S_ERR);
        done_n       = (state_n == S_FIN);
        error_n      = (state_n == S_ERR);
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic core_hold, done, error;

    imem_loader_if #(.ADDR_W(6)) bus ();

    imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Cycle stamp and write log.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_n = 0;
    logic [5:0]  wr_addr [0:31];
    logic [31:0] wr_data [0:31];
    int          wr_cyc  [0:31];
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_n < 32) begin
                wr_addr[wr_n] = bus.mem_addr;
                wr_data[wr_n] = bus.mem_wdata;
                wr_cyc[wr_n]  = cyc;
            end
            wr_n = wr_n + 1;
        end
    end

    // Stimulus byte list and expected words.
    logic [7:0]  stim  [0:31];
    int          stim_n;
    logic [31:0] exp_w [0:7];
    int          exp_n;

    task automatic stim_clear();
        stim_n = 0;
        exp_n  = 0;
    endtask

    task automatic push(input logic [7:0] b);
        stim[stim_n] = b;
        stim_n++;
    endtask

    task automatic push_word(input logic [31:0] w);
        push(w[7:0]);
        push(w[15:8]);
        push(w[23:16]);
        push(w[31:24]);
        exp_w[exp_n] = w;
        exp_n++;
    endtask

    task automatic idle(input int n);
        bus.byte_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Present one byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
        int wait_n;
        if (gap) begin
            bus.byte_valid = 1'b0;
            start = pulse;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        wait_n = 0;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && wait_n < 16) begin
            wait_n++;
            @(negedge clk);
        end
        if (bus.byte_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL handshake_timeout byte=%02h byte_ready=%b required 1", b, bus.byte_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int from, input int to, input bit gap, input int pulse_a, input int pulse_b);
        for (int i = from; i <= to; i++) begin
            send_byte(stim[i], gap && (i > from), (i == pulse_a) || (i == pulse_b));
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, error} !== 43'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b we=%b addr=%0d wdata=%08h hold=%b done=%b err=%b required all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, error);
        end
        rst_n = 1'b1;
        idle(2);
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle_after_reset got %b required 0000", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    task automatic test_good_load();
        int base;
        base = wr_n;
        pulse_start();
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0011) begin
            miscompares++;
            $display("FAIL start_status got %b required 0011", {done, error, core_hold, bus.byte_ready});
        end
        stim_clear();
        push(8'h02); push(8'h00);
        push_word(32'h00500093);
        push_word(32'h00A00113);
        push(8'h71);
        send_range(0, 5, 1'b0, -1, -1);
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 6'd0, 32'h00500093}) begin
            miscompares++;
            $display("FAIL write_latency got we=%b addr=%0d data=%08h required we=1 addr=0 data=00500093",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        idle(1);
        vectors++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b0, 6'd1, 32'h00500093}) begin
            miscompares++;
            $display("FAIL write_pulse_end got we=%b addr=%0d data=%08h required we=0 addr=1 data=00500093",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        send_range(6, 10, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if (wr_n - base !== exp_n) begin
            miscompares++;
            $display("FAIL good_write_count got %0d required %0d", wr_n - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if ({wr_addr[base+i], wr_data[base+i]} !== {6'(i), exp_w[i]}) begin
                miscompares++;
                $display("FAIL good_write%0d got addr=%0d data=%08h required addr=%0d data=%08h",
                         i, wr_addr[base+i], wr_data[base+i], i, exp_w[i]);
            end
        end
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL good_status got %b required 1000", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_n;
        pulse_start();
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0011) begin
            miscompares++;
            $display("FAIL restart_from_fin got %b required 0011", {done, error, core_hold, bus.byte_ready});
        end
        stim_clear();
        push(8'h02); push(8'h00);
        push_word(32'h00500093);
        push_word(32'h00A00113);
        push(8'h00);
        send_range(0, stim_n - 1, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if (wr_n - base !== exp_n) begin
            miscompares++;
            $display("FAIL badsum_write_count got %0d required %0d", wr_n - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if ({wr_addr[base+i], wr_data[base+i]} !== {6'(i), exp_w[i]}) begin
                miscompares++;
                $display("FAIL badsum_write%0d got addr=%0d data=%08h required addr=%0d data=%08h",
                         i, wr_addr[base+i], wr_data[base+i], i, exp_w[i]);
            end
        end
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0110) begin
            miscompares++;
            $display("FAIL badsum_status got %b required 0110", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    task automatic test_len_overflow();
        int base;
        base = wr_n;
        pulse_start();
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0011) begin
            miscompares++;
            $display("FAIL restart_from_err got %b required 0011", {done, error, core_hold, bus.byte_ready});
        end
        stim_clear();
        push(8'h41); push(8'h00);
        send_range(0, 1, 1'b0, -1, -1);
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0110) begin
            miscompares++;
            $display("FAIL overflow_status got %b required 0110", {done, error, core_hold, bus.byte_ready});
        end
        idle(6);
        vectors++;
        if (wr_n - base !== 0) begin
            miscompares++;
            $display("FAIL overflow_write_count got %0d required 0", wr_n - base);
        end
    endtask

    task automatic test_zero_len();
        int base;
        base = wr_n;
        pulse_start();
        stim_clear();
        push(8'h00); push(8'h00); push(8'h00);
        send_range(0, 2, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL zero_len_good_status got %b required 1000", {done, error, core_hold, bus.byte_ready});
        end
        pulse_start();
        stim_clear();
        push(8'h00); push(8'h00); push(8'h01);
        send_range(0, 2, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0110) begin
            miscompares++;
            $display("FAIL zero_len_bad_status got %b required 0110", {done, error, core_hold, bus.byte_ready});
        end
        vectors++;
        if (wr_n - base !== 0) begin
            miscompares++;
            $display("FAIL zero_len_write_count got %0d required 0", wr_n - base);
        end
    endtask

    task automatic test_toggle_start();
        int base;
        base = wr_n;
        pulse_start();
        stim_clear();
        push(8'h02); push(8'h00);
        push_word(32'h00500093);
        push_word(32'h00A00113);
        push(8'h71);
        // Start pulses land in gap cycles while the loader is in DATA.
        send_range(0, stim_n - 1, 1'b1, 4, 8);
        idle(2);
        vectors++;
        if (wr_n - base !== exp_n) begin
            miscompares++;
            $display("FAIL toggle_write_count got %0d required %0d", wr_n - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if ({wr_addr[base+i], wr_data[base+i]} !== {6'(i), exp_w[i]}) begin
                miscompares++;
                $display("FAIL toggle_write%0d got addr=%0d data=%08h required addr=%0d data=%08h",
                         i, wr_addr[base+i], wr_data[base+i], i, exp_w[i]);
            end
        end
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL toggle_status got %b required 1000", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = wr_n;
        pulse_start();
        stim_clear();
        push(8'h03); push(8'h00);
        push_word(32'h11223344);
        push_word(32'h55667788);
        push_word(32'hDEADBEEF);
        push(8'hAA);
        send_range(0, stim_n - 1, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if (wr_n - base !== exp_n) begin
            miscompares++;
            $display("FAIL b2b_write_count got %0d required %0d", wr_n - base, exp_n);
        end
        for (int i = 0; i < exp_n; i++) begin
            vectors++;
            if ({wr_addr[base+i], wr_data[base+i]} !== {6'(i), exp_w[i]}) begin
                miscompares++;
                $display("FAIL b2b_write%0d got addr=%0d data=%08h required addr=%0d data=%08h",
                         i, wr_addr[base+i], wr_data[base+i], i, exp_w[i]);
            end
        end
        for (int i = 1; i < exp_n; i++) begin
            vectors++;
            if (wr_cyc[base+i] - wr_cyc[base+i-1] !== 4) begin
                miscompares++;
                $display("FAIL b2b_spacing%0d got %0d cycles required 4", i, wr_cyc[base+i] - wr_cyc[base+i-1]);
            end
        end
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL b2b_status got %b required 1000", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    task automatic test_mid_reset();
        int base;
        pulse_start();
        stim_clear();
        push(8'h02); push(8'h00);
        push_word(32'h00500093);
        push_word(32'h00A00113);
        push(8'h71);
        send_range(0, 6, 1'b0, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, error} !== 43'd0) begin
            miscompares++;
            $display("FAIL async_reset got rdy=%b we=%b addr=%0d wdata=%08h hold=%b done=%b err=%b required all 0",
                     bus.byte_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_hold, done, error);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset_idle got %b required 0000", {done, error, core_hold, bus.byte_ready});
        end
        base = wr_n;
        pulse_start();
        stim_clear();
        push(8'h01); push(8'h00);
        push_word(32'h12345678);
        push(8'h08);
        send_range(0, stim_n - 1, 1'b0, -1, -1);
        idle(2);
        vectors++;
        if (wr_n - base !== 1) begin
            miscompares++;
            $display("FAIL reload_write_count got %0d required 1", wr_n - base);
        end
        vectors++;
        if ({wr_addr[base], wr_data[base]} !== {6'd0, 32'h12345678}) begin
            miscompares++;
            $display("FAIL reload_write got addr=%0d data=%08h required addr=0 data=12345678",
                     wr_addr[base], wr_data[base]);
        end
        vectors++;
        if ({done, error, core_hold, bus.byte_ready} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reload_status got %b required 1000", {done, error, core_hold, bus.byte_ready});
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_len_overflow();
        test_zero_len();
        test_toggle_start();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
